// File: rtl/bounded_updown_counter.sv
// rtl/bounded_updown_counter.sv - bounded up/down counter with reject/saturate/wrap policy and sticky flags
module bounded_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter int MIN_COUNT = 0,
  parameter int EVT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increment,
  input  logic             decrement,
  input  logic [WIDTH-1:0] amount,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic [EVT_W-1:0] evt_count,
  output logic             at_max,
  output logic             at_min
);

  localparam int W1 = WIDTH + 1;
  localparam logic [W1-1:0]    MAX_X   = W1'(MAX_COUNT);
  localparam logic [W1-1:0]    MIN_X   = W1'(MIN_COUNT);
  localparam logic [W1-1:0]    RANGE_X = W1'(MAX_COUNT - MIN_COUNT + 1);
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MIN_C   = WIDTH'(MIN_COUNT);
  localparam logic [EVT_W-1:0] EVT_SAT = '1;

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_WRAP = 2'b10;

  logic [W1-1:0]    sum;
  logic [W1-1:0]    diff;
  logic             wrap_ok;
  logic             do_inc;
  logic             do_dec;
  logic             over_evt;
  logic             under_evt;
  logic [WIDTH-1:0] next_count;

  always_comb begin
    sum        = {1'b0, count} + {1'b0, amount};
    diff       = {1'b0, count} - {1'b0, amount};
    wrap_ok    = {1'b0, amount} < RANGE_X;
    do_inc     = !load && increment && !decrement;
    do_dec     = !load && decrement && !increment;
    over_evt   = do_inc && (sum > MAX_X);
    under_evt  = do_dec && ($signed(diff) < $signed(MIN_X));
    next_count = count;

    // With amount < RANGE the modulo reduces to a single +/- RANGE correction.
    if (load) begin
      if (load_value < MIN_C)      next_count = MIN_C;
      else if (load_value > MAX_C) next_count = MAX_C;
      else                         next_count = load_value;
    end else if (do_inc) begin
      if (!over_evt)                            next_count = WIDTH'(sum);
      else if (mode == MODE_SAT)                next_count = MAX_C;
      else if (mode == MODE_WRAP && wrap_ok)    next_count = WIDTH'(sum - RANGE_X);
    end else if (do_dec) begin
      if (!under_evt)                           next_count = WIDTH'(diff);
      else if (mode == MODE_SAT)                next_count = MIN_C;
      else if (mode == MODE_WRAP && wrap_ok)    next_count = WIDTH'(diff + RANGE_X);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= MIN_C;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      evt_count <= '0;
    end else begin
      count <= next_count;

      if (over_evt) begin
        overflow  <= 1'b1;
        underflow <= 1'b0;
      end else if (under_evt) begin
        overflow  <= 1'b0;
        underflow <= 1'b1;
      end else if (load || do_inc || do_dec || clear_flags) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end

      // An event in the same cycle as clear_flags restarts the tally at one.
      if (over_evt || under_evt) begin
        if (clear_flags)               evt_count <= EVT_W'(1);
        else if (evt_count != EVT_SAT) evt_count <= evt_count + EVT_W'(1);
      end else if (clear_flags) begin
        evt_count <= '0;
      end
    end
  end

  assign at_max = (count == MAX_C);
  assign at_min = (count == MIN_C);

endmodule

// File: tb/tb_bounded_updown_counter.sv
// tb/tb_bounded_updown_counter.sv - directed vector bench for bounded_updown_counter
module tb_bounded_updown_counter;

  localparam logic [1:0] REJ  = 2'b00;
  localparam logic [1:0] SAT  = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;
  localparam logic [1:0] REJ3 = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       increment;
  logic       decrement;
  logic [7:0] amount;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_value;
  logic       clear_flags;
  logic [7:0] count;
  logic       overflow;
  logic       underflow;
  logic [3:0] evt_count;
  logic       at_max;
  logic       at_min;

  int checks = 0;
  int errors = 0;

  bounded_updown_counter #(
    .WIDTH(8), .MAX_COUNT(200), .MIN_COUNT(10), .EVT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .increment(increment), .decrement(decrement),
    .amount(amount), .mode(mode), .load(load), .load_value(load_value),
    .clear_flags(clear_flags), .count(count), .overflow(overflow),
    .underflow(underflow), .evt_count(evt_count), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inc;
    logic       dec;
    logic [7:0] amt;
    logic [1:0] md;
    logic       ld;
    logic [7:0] ldv;
    logic       clr;
    logic [7:0] cnt;
    logic       ovf;
    logic       udf;
    logic [3:0] evt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic inc, input logic dec, input logic [7:0] amt,
                     input logic [1:0] md, input logic ld, input logic [7:0] ldv,
                     input logic clr, input logic [7:0] cnt, input logic ovf,
                     input logic udf, input logic [3:0] evt);
    vec_t v;
    v = '{inc, dec, amt, md, ld, ldv, clr, cnt, ovf, udf, evt};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input int ovf,
                           input int udf, input int evt);
    check({tag, " count"}, int'(count), cnt);
    check({tag, " overflow"}, int'(overflow), ovf);
    check({tag, " underflow"}, int'(underflow), udf);
    check({tag, " evt_count"}, int'(evt_count), evt);
    check({tag, " at_max"}, int'(at_max), (cnt == 200) ? 1 : 0);
    check({tag, " at_min"}, int'(at_min), (cnt == 10) ? 1 : 0);
  endtask

  task automatic drive(input logic inc, input logic dec, input logic [7:0] amt,
                       input logic [1:0] md, input logic ld, input logic [7:0] ldv,
                       input logic clr);
    increment   = inc;
    decrement   = dec;
    amount      = amt;
    mode        = md;
    load        = ld;
    load_value  = ldv;
    clear_flags = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   inc  dec  amt  mode  ld  ldv  clr  cnt  ovf udf evt
    add(1, 0, 50,  SAT,  0, 0,   0, 60,  0, 0, 0);
    add(0, 0, 0,   SAT,  1, 190, 0, 190, 0, 0, 0);
    add(1, 0, 20,  SAT,  0, 0,   0, 200, 1, 0, 1);
    add(0, 0, 0,   SAT,  1, 190, 0, 190, 0, 0, 1);
    add(1, 0, 20,  REJ,  0, 0,   0, 190, 1, 0, 2);
    add(1, 0, 20,  WRAP, 0, 0,   0, 19,  1, 0, 3);
    add(0, 0, 0,   SAT,  1, 15,  0, 15,  0, 0, 3);
    add(0, 1, 10,  SAT,  0, 0,   0, 10,  0, 1, 4);
    add(1, 0, 0,   SAT,  0, 0,   0, 10,  0, 0, 4);
    add(1, 1, 30,  SAT,  0, 0,   0, 10,  0, 0, 4);
    add(0, 1, 5,   REJ3, 0, 0,   0, 10,  0, 1, 5);
    add(1, 1, 5,   SAT,  0, 0,   0, 10,  0, 1, 5);
    add(0, 0, 0,   SAT,  1, 250, 0, 200, 0, 0, 5);
    add(0, 1, 15,  WRAP, 0, 0,   0, 185, 0, 0, 5);
    add(0, 0, 0,   WRAP, 1, 12,  0, 12,  0, 0, 5);
    add(0, 1, 5,   WRAP, 0, 0,   0, 198, 0, 1, 6);
    add(1, 0, 191, WRAP, 0, 0,   0, 198, 1, 0, 7);
    add(0, 0, 0,   SAT,  1, 3,   0, 10,  0, 0, 7);
    add(0, 0, 0,   SAT,  0, 0,   1, 10,  0, 0, 0);
    add(1, 0, 190, WRAP, 0, 0,   0, 200, 0, 0, 0);
    add(0, 1, 190, SAT,  0, 0,   0, 10,  0, 0, 0);
    add(0, 1, 5,   SAT,  1, 100, 0, 100, 0, 0, 0);

    drive(0, 0, 0, REJ, 0, 0, 0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all("reset_async", 10, 0, 0, 0);
    step();
    check_all("reset_held", 10, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].inc, vecs[i].dec, vecs[i].amt, vecs[i].md,
            vecs[i].ld, vecs[i].ldv, vecs[i].clr);
      step();
      check_all($sformatf("vec%0d", i), int'(vecs[i].cnt), int'(vecs[i].ovf),
                int'(vecs[i].udf), int'(vecs[i].evt));
    end

    // Reset between edges with an increment pending; count must drop at once.
    drive(1, 0, 5, SAT, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("midreset_async", 10, 0, 0, 0);
    step();
    check_all("midreset_held", 10, 0, 0, 0);
    reset = 1'b0;
    step();
    check_all("post_release_inc", 15, 0, 0, 0);

    // Event counter saturation at the upper bound in reject mode.
    drive(0, 0, 0, REJ, 1, 200, 0);
    step();
    check_all("load_max", 200, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 20, REJ, 0, 0, 0);
      step();
      check_all($sformatf("sat_evt%0d", i), 200, 1, 0, (i + 1 > 15) ? 15 : i + 1);
    end

    drive(1, 0, 1, REJ, 0, 0, 1);
    step();
    check_all("clr_with_ovf", 200, 1, 0, 1);
    drive(0, 1, 5, SAT, 0, 0, 1);
    step();
    check_all("clr_with_ok", 195, 0, 0, 0);
    drive(0, 1, 200, SAT, 0, 0, 1);
    step();
    check_all("clr_with_udf", 10, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bounded_updown_counter.md
Name: bounded_updown_counter

Overview:
Parametrised up/down counter with programmable bounds, a selectable overflow policy (reject, saturate or wrap), and sticky overflow/underflow flags. It also keeps a saturating count of out-of-range events and supports synchronous load and flag clear. It is the general-width successor of the team's 8-bit step counter and drives status LEDs and the control logic that needs a bounded running total.

Parameters:
WIDTH, 8, bit width of count, amount and load_value
MAX_COUNT, 255, inclusive upper bound; must be < 2**WIDTH and > MIN_COUNT
MIN_COUNT, 0, inclusive lower bound; count reset value
EVT_W, 4, width of the out-of-range event counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
increment  input  1  add amount this cycle
decrement  input  1  subtract amount this cycle
amount  input  WIDTH  step size, unsigned
mode  input  2  00/11 REJECT, 01 SATURATE, 10 WRAP; sampled each cycle
load  input  1  synchronous load of load_value
load_value  input  WIDTH  value to load, clamped to [MIN_COUNT, MAX_COUNT]
clear_flags  input  1  clears overflow, underflow and evt_count
count  output  WIDTH  registered count
overflow  output  1  sticky flag: last out-of-range op was an increment
underflow  output  1  sticky flag: last out-of-range op was a decrement
evt_count  output  EVT_W  saturating count of overflow and underflow events
at_max  output  1  count == MAX_COUNT, decoded combinationally from the register
at_min  output  1  count == MIN_COUNT, decoded combinationally from the register

Behaviour:
- Reset is asynchronous. While reset is high, outputs are held at: count = MIN_COUNT, overflow = 0, underflow = 0, evt_count = 0. Release is synchronous to clk.
- Priority per edge is fixed: load > (increment and decrement both high = idle) > increment > decrement > idle.
- Arithmetic is done in WIDTH+1 bits. RANGE = MAX_COUNT - MIN_COUNT + 1.
- Load: count <= clamp(load_value). Both flags are cleared. evt_count is unchanged.
- Increment: sum = count + amount.
  - If sum <= MAX_COUNT: count <= sum. The op is successful.
  - Otherwise it is an overflow event:
    - REJECT: count holds.
    - SATURATE: count <= MAX_COUNT.
    - WRAP: count <= MIN_COUNT + ((count - MIN_COUNT + amount) mod RANGE), valid only when amount < RANGE. If amount >= RANGE, the op behaves as REJECT.
- Decrement: mirrors increment. An underflow event occurs when count - amount < MIN_COUNT (signed compare in WIDTH+1 bits).
  - REJECT: hold.
  - SATURATE: count <= MIN_COUNT.
  - WRAP: count <= MAX_COUNT - ((MIN_COUNT - (count - amount) - 1) mod RANGE), same amount < RANGE rule.
- amount = 0 is a successful op: count is unchanged and the flags are cleared.
- Flags:
  - A successful increment or decrement clears both flags.
  - An overflow event sets overflow = 1 and underflow = 0.
  - An underflow event sets underflow = 1 and overflow = 0.
  - Idle cycles hold the flags.
- evt_count increments by 1 on each overflow or underflow event and saturates at all-ones.
- clear_flags zeroes overflow, underflow and evt_count. If an event occurs in the same cycle, the event wins: its flag is set and evt_count is 1.
- All updates are visible the cycle after the sampling edge; latency is 1. at_max and at_min track count with no added latency.
- Asserting reset mid-operation discards any pending update. The first edge after release counts from MIN_COUNT.

Test Plan:
Configuration for all scenarios: WIDTH=8, MIN_COUNT=10, MAX_COUNT=200, EVT_W=4.
1. Assert reset, release, then increment with amount=50 -> count=10, at_min=1 during reset; count=60 one cycle later; flags 0.
2. Load 190, then increment with amount=20 -> SATURATE gives count=200, overflow=1, at_max=1, evt_count=1; REJECT gives 190; WRAP gives 19.
3. From count=15, decrement with amount=10 in SATURATE -> count=10, underflow=1, overflow=0. A following increment with amount=0 clears underflow and leaves count=10.
4. Increment and decrement both high -> count and flags hold. Load 250 -> count=200. Load 3 -> count=10, flags cleared.
5. From count=100, assert reset between edges -> count=10 immediately, before the next edge. Release, then increment 5 -> 15.
6. At count=200 in REJECT, apply 20 overflowing increments -> evt_count stops at 15. clear_flags with an overflowing increment in the same cycle -> overflow=1, evt_count=1.
